// File: rtl/mmc_spi_master.sv
// mmc_spi_master: SPI mode-0 master sending 16-bit frames {rw, addr[6:0], data[7:0]} with a valid/ready command port.
// Define MMC_SPI_MASTER_BURST_EN to add cmd_last and address-auto-increment byte bursts within one CSB window.
module mmc_spi_master #(
   parameter int DIV = 4,
   parameter int AW  = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rw,
   input  logic [AW-1:0] cmd_addr,
   input  logic [7:0]    cmd_wdata,
`ifdef MMC_SPI_MASTER_BURST_EN
   input  logic          cmd_last,
`endif
   output logic          done,
   output logic [7:0]    rdata,
   output logic          busy,
   output logic          SCLK,
   output logic          CSB,
   output logic          MOSI,
   input  logic          MISO
);
   if (DIV < 2 || DIV > 255 || AW != 7) begin : g_bad_param
      $error("mmc_spi_master: DIV must be 2..255 and AW must be 7");
   end

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
   localparam logic [7:0] DEND = 8'(DIV - 1);

   state_t      state;
   logic [7:0]  dc;
   logic [4:0]  bc;
   logic [15:0] sr;
   logic        last;
   logic        last_in;
   logic        half_end;

`ifdef MMC_SPI_MASTER_BURST_EN
   assign last_in = cmd_last;
`else
   assign last_in = 1'b1;
`endif
   assign half_end = dc == DEND;

   // sr shifts MOSI bits out of the top and MISO samples in at the bottom on each rising SCLK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dc        <= 8'd0;
         bc        <= 5'd0;
         sr        <= 16'd0;
         last      <= 1'b1;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rdata     <= 8'd0;
         SCLK      <= 1'b0;
         CSB       <= 1'b1;
         MOSI      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  state     <= SETUP;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  CSB       <= 1'b0;
                  dc        <= 8'd0;
                  bc        <= 5'd0;
                  sr        <= {cmd_rw, cmd_addr, cmd_wdata};
                  MOSI      <= cmd_rw;
                  last      <= last_in;
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            SETUP: begin
               dc <= half_end ? 8'd0 : dc + 8'd1;
               if (half_end) begin
                  state <= SHIFT;
                  SCLK  <= 1'b1;
                  sr    <= {sr[14:0], MISO};
               end
            end
            SHIFT: begin
               dc <= half_end ? 8'd0 : dc + 8'd1;
               // one-cycle ready window ending exactly at the byte boundary
               cmd_ready <= bc == 5'd15 && !SCLK && dc == DEND - 8'd1 && !last;
               if (half_end && SCLK) begin
                  SCLK <= 1'b0;
                  MOSI <= bc == 5'd15 ? 1'b0 : sr[15];
               end else if (half_end && bc != 5'd15) begin
                  SCLK <= 1'b1;
                  bc   <= bc + 5'd1;
                  sr   <= {sr[14:0], MISO};
               end else if (half_end) begin
                  done  <= 1'b1;
                  rdata <= sr[7:0];
                  if (cmd_valid && cmd_ready) begin
                     state <= SETUP;
                     bc    <= 5'd8;
                     sr    <= {cmd_wdata, 8'h00};
                     MOSI  <= cmd_wdata[7];
                     last  <= last_in;
                  end else begin
                     state <= GAP;
                     CSB   <= 1'b1;
                  end
               end
            end
            GAP: begin
               dc <= half_end ? 8'd0 : dc + 8'd1;
               if (half_end) begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
         endcase
      end
   end
endmodule
